// File: rtl/exec_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : exec_unit_pipe
// Purpose  : Single registered execute stage sitting between decode and
//            memory. It contains a width-generic ALU with saturating add/sub,
//            XOR, shifts/rotate, byte-lane loads and pass-through ops, and an
//            iterative shift-add multiplier that stalls decode while it runs.
//            It also keeps the {N,Z,V} flag register used by branch resolution.
// Ports    : clk, rst (async, active-high), flush (sync squash)
//            in_valid/in_ready, in_op, in_src1, in_src2, in_tag  - decode side
//            out_valid/out_ready, out_result, out_tag            - memory side
//            flags {N,Z,V}, busy (multiplier iterating)
// Revision : 1.0 - initial release
// ============================================================================
module exec_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       flags,
  output logic             busy
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = SHW + 1;
  localparam int MSB   = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_SLL  = 4'h4;
  localparam logic [3:0] OP_SRA  = 4'h5;
  localparam logic [3:0] OP_ROR  = 4'h6;
  localparam logic [3:0] OP_PASS = 4'h8;
  localparam logic [3:0] OP_LLB  = 4'h9;
  localparam logic [3:0] OP_LHB  = 4'hA;
  localparam logic [3:0] OP_ADDW = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hE;

  // Which flag bits an op is allowed to write.
  localparam logic [1:0] FL_HOLD = 2'd0;
  localparam logic [1:0] FL_NZV  = 2'd1;
  localparam logic [1:0] FL_Z    = 2'd2;

  localparam logic [WIDTH-1:0] SAT_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic [TAG_W-1:0] tag_q,       tag_d;
  logic [2:0]       flags_q,     flags_d;
  logic             busy_q,      busy_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] mcand_q,     mcand_d;
  logic [WIDTH-1:0] mplier_q,    mplier_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [TAG_W-1:0] mtag_q,      mtag_d;

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   sum_wrap;
  logic [WIDTH-1:0]   diff_wrap;
  logic               add_ovf;
  logic               sub_ovf;
  logic [2*WIDTH-1:0] ror_wide;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;
  logic [1:0]         alu_fmode;

  assign shamt     = in_src2[SHW-1:0];
  assign sum_wrap  = in_src1 + in_src2;
  assign diff_wrap = in_src1 - in_src2;
  assign add_ovf   = (in_src1[MSB] == in_src2[MSB]) && (sum_wrap[MSB]  != in_src1[MSB]);
  assign sub_ovf   = (in_src1[MSB] != in_src2[MSB]) && (diff_wrap[MSB] != in_src1[MSB]);
  // Rotating a doubled copy makes the low half the rotated word for any amount.
  assign ror_wide  = {in_src1, in_src1} >> shamt;

  always_comb begin
    alu_res   = '0;
    alu_v     = 1'b0;
    alu_fmode = FL_HOLD;
    case (in_op)
      // On overflow the clamp direction follows src1's sign: both operands
      // (after SUB's negation) share it.
      OP_ADD: begin
        alu_res   = add_ovf ? (in_src1[MSB] ? SAT_NEG : SAT_POS) : sum_wrap;
        alu_v     = add_ovf;
        alu_fmode = FL_NZV;
      end
      OP_SUB: begin
        alu_res   = sub_ovf ? (in_src1[MSB] ? SAT_NEG : SAT_POS) : diff_wrap;
        alu_v     = sub_ovf;
        alu_fmode = FL_NZV;
      end
      OP_XOR: begin
        alu_res   = in_src1 ^ in_src2;
        alu_fmode = FL_Z;
      end
      OP_SLL: begin
        alu_res   = in_src1 << shamt;
        alu_fmode = FL_Z;
      end
      OP_SRA: begin
        alu_res   = $unsigned($signed(in_src1) >>> shamt);
        alu_fmode = FL_Z;
      end
      OP_ROR: begin
        alu_res   = ror_wide[WIDTH-1:0];
        alu_fmode = FL_Z;
      end
      OP_PASS: alu_res = in_src1;
      OP_LLB:  alu_res = {in_src1[WIDTH-1:WIDTH/2], in_src2[WIDTH/2-1:0]};
      OP_LHB:  alu_res = {in_src2[WIDTH/2-1:0], in_src1[WIDTH/2-1:0]};
      OP_ADDW: alu_res = sum_wrap;
      default: alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshake and next-state
  // --------------------------------------------------------------------------
  logic             accept;
  logic [WIDTH-1:0] acc_step;

  assign in_ready = !busy_q && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    tag_d       = tag_q;
    flags_d     = flags_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    mtag_d      = mtag_q;

    if (flush) begin
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      cnt_d       = '0;
    end else if (busy_q) begin
      // One multiplier bit per cycle; out_valid is already low here because
      // the MUL could only be accepted with the output register free.
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_step;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == MUL_LAST) begin
        busy_d      = 1'b0;
        out_valid_d = 1'b1;
        result_d    = acc_step;
        tag_d       = mtag_q;
        flags_d[1]  = (acc_step == '0);
      end
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (in_op == OP_MUL) begin
          busy_d      = 1'b1;
          cnt_d       = '0;
          mcand_d     = in_src1;
          mplier_d    = in_src2;
          acc_d       = '0;
          mtag_d      = in_tag;
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
          result_d    = alu_res;
          tag_d       = in_tag;
          case (alu_fmode)
            FL_NZV:  flags_d    = {alu_res[MSB], (alu_res == '0), alu_v};
            FL_Z:    flags_d[1] = (alu_res == '0);
            default: flags_d    = flags_q;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
      flags_q     <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      mtag_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      tag_q       <= tag_d;
      flags_q     <= flags_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      mtag_q      <= mtag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_tag    = tag_q;
  assign flags      = flags_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_unit_pipe
// Purpose  : Self-checking bench for exec_unit_pipe. A transaction-level
//            reference model (integer arithmetic, a multiply countdown and an
//            expected output slot) predicts every cycle's handshake, result,
//            tag, flags and busy. Directed scenarios come first, then a long
//            randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_unit_pipe;

  localparam int W  = 16;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [W-1:0]  in_src1;
  logic [W-1:0]  in_src2;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic [2:0]    flags;
  logic          busy;

  always #5 clk = ~clk;

  exec_unit_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .flags      (flags),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic          m_valid;
  logic [W-1:0]  m_result;
  logic [TW-1:0] m_tag;
  logic [2:0]    m_flags;
  int            m_mul_left;
  logic [W-1:0]  m_mul_res;
  logic [TW-1:0] m_mul_tag;

  task automatic model_reset();
    m_valid    = 1'b0;
    m_result   = '0;
    m_tag      = '0;
    m_flags    = 3'b000;
    m_mul_left = 0;
    m_mul_res  = '0;
    m_mul_tag  = '0;
  endtask

  // fmode: 0 = flags untouched, 1 = N,Z,V written, 2 = only Z written
  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] r,
                                 output int fmode, output logic v);
    longint          sa, sb, s, maxp, minn;
    longint unsigned ua, ub, m, h, t;
    int              sh;
    sa    = $signed(a);
    sb    = $signed(b);
    ua    = a;
    ub    = b;
    m     = 64'd1 << W;
    h     = 64'd1 << (W / 2);
    maxp  = (64'sd1 <<< (W - 1)) - 1;
    minn  = -(64'sd1 <<< (W - 1));
    sh    = int'(ub % W);
    r     = '0;
    v     = 1'b0;
    fmode = 0;
    t     = 0;
    case (op)
      4'h0, 4'h1: begin
        s     = (op == 4'h0) ? sa + sb : sa - sb;
        fmode = 1;
        if (s > maxp) begin
          r = maxp[W-1:0];
          v = 1'b1;
        end else if (s < minn) begin
          r = minn[W-1:0];
          v = 1'b1;
        end else begin
          r = s[W-1:0];
        end
      end
      4'h2: begin r = a ^ b; fmode = 2; end
      4'h4: begin t = (ua << sh) % m; r = t[W-1:0]; fmode = 2; end
      4'h5: begin s = sa >>> sh; r = s[W-1:0]; fmode = 2; end
      4'h6: begin t = ((ua >> sh) | (ua << (W - sh))) % m; r = t[W-1:0]; fmode = 2; end
      4'h8: r = a;
      4'h9: begin t = (ua / h) * h + (ub % h); r = t[W-1:0]; end
      4'hA: begin t = (ub % h) * h + (ua % h); r = t[W-1:0]; end
      4'hB: begin t = (ua + ub) % m; r = t[W-1:0]; end
      4'hE: begin t = (ua * ub) % m; r = t[W-1:0]; fmode = 2; end
      default: r = '0;
    endcase
  endfunction

  function automatic logic [2:0] upd_flags(input logic [2:0] f, input logic [W-1:0] r,
                                           input int fmode, input logic v);
    if (fmode == 1) return {r[W-1], (r == '0), v};
    if (fmode == 2) return {f[2], (r == '0), f[0]};
    return f;
  endfunction

  // One clock: check in_ready against the model, advance the model over the
  // edge, then check all registered outputs. Inputs are already driven.
  task automatic cycle();
    logic         exp_rdy;
    logic         acc;
    logic [W-1:0] r;
    int           fm;
    logic         v;
    #1;
    exp_rdy = (m_mul_left == 0) && !flush && (!m_valid || out_ready);
    check("in_ready", in_ready, exp_rdy);
    acc = in_valid && exp_rdy;
    @(posedge clk);
    if (flush) begin
      m_valid    = 1'b0;
      m_mul_left = 0;
    end else if (m_mul_left > 0) begin
      m_mul_left--;
      if (m_mul_left == 0) begin
        m_valid  = 1'b1;
        m_result = m_mul_res;
        m_tag    = m_mul_tag;
        m_flags  = upd_flags(m_flags, m_mul_res, 2, 1'b0);
      end
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (acc) begin
        ref_op(in_op, in_src1, in_src2, r, fm, v);
        if (in_op == 4'hE) begin
          m_mul_left = W;
          m_mul_res  = r;
          m_mul_tag  = in_tag;
          m_valid    = 1'b0;
        end else begin
          m_valid  = 1'b1;
          m_result = r;
          m_tag    = in_tag;
          m_flags  = upd_flags(m_flags, r, fm, v);
        end
      end
    end
    #1;
    check("out_valid", out_valid, m_valid);
    check("busy", busy, m_mul_left > 0);
    check("flags", flags, m_flags);
    if (m_valid) begin
      check("out_result", out_result, m_result);
      check("out_tag", out_tag, m_tag);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_op     = op;
    in_src1   = a;
    in_src2   = b;
    in_tag    = tag;
    out_ready = rdy;
    flush     = fl;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [2:0] saved_flags;
  logic [3:0] op_tab [12] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6,
                              4'h8, 4'h9, 4'hA, 4'hB, 4'h3, 4'hF};

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h0, '0, '0, '0, 1'b1, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 16'h0000);
    check("rst_out_tag", out_tag, 32'h0);
    check("rst_flags", flags, 3'b000);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", in_ready, 1'b1);

    // Saturating arithmetic and flag behaviour
    drive(1'b1, 4'h0, 16'h7FFF, 16'h0001, 32'hA000_0001, 1'b1, 1'b0); cycle();
    check("add_sat_res", out_result, 16'h7FFF);
    check("add_sat_flags", flags, 3'b001);
    drive(1'b1, 4'h1, 16'h0005, 16'h0005, 32'hA000_0002, 1'b1, 1'b0); cycle();
    check("sub_zero_res", out_result, 16'h0000);
    check("sub_zero_flags", flags, 3'b010);
    drive(1'b1, 4'h1, 16'h8000, 16'h0001, 32'hA000_0003, 1'b1, 1'b0); cycle();
    check("sub_sat_res", out_result, 16'h8000);
    check("sub_sat_flags", flags, 3'b101);
    drive(1'b1, 4'h2, 16'h00FF, 16'h00FF, 32'hA000_0004, 1'b1, 1'b0); cycle();
    check("xor_res", out_result, 16'h0000);
    check("xor_flags", flags, 3'b111);
    drive(1'b1, 4'h6, 16'h0001, 16'h0001, 32'hA000_0005, 1'b1, 1'b0); cycle();
    check("ror_res", out_result, 16'h8000);
    check("ror_flags", flags, 3'b101);
    drive(1'b1, 4'h5, 16'h8000, 16'h000F, 32'hA000_0006, 1'b1, 1'b0); cycle();
    check("sra_res", out_result, 16'hFFFF);

    // Back-pressure: second ADD waits until out_ready rises
    drive(1'b1, 4'h0, 16'h0010, 16'h0020, 32'hB000_0001, 1'b1, 1'b0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h0, 16'h0100, 16'h0200, 32'hB000_0002, 1'b0, 1'b0); cycle();
      check("bp_held_res", out_result, 16'h0030);
      check("bp_held_tag", out_tag, 32'hB000_0001);
    end
    drive(1'b1, 4'h0, 16'h0100, 16'h0200, 32'hB000_0002, 1'b1, 1'b0); cycle();
    check("bp_second_res", out_result, 16'h0300);
    check("bp_second_tag", out_tag, 32'hB000_0002);

    // Multiplier: decode keeps offering an ADD that must not be taken
    drive(1'b1, 4'hE, 16'h0003, 16'h0005, 32'hC000_0001, 1'b1, 1'b0); cycle();
    for (int i = 1; i <= W; i++) begin
      drive(1'b1, 4'h0, 16'h1111, 16'h1111, 32'hDEAD_0000, 1'b1, 1'b0); cycle();
    end
    check("mul_res", out_result, 16'h000F);
    check("mul_tag", out_tag, 32'hC000_0001);
    check("mul_valid", out_valid, 1'b1);
    drive(1'b1, 4'hE, 16'hFFFF, 16'hFFFF, 32'hC000_0002, 1'b1, 1'b0); cycle();
    repeat (W) begin
      drive(1'b0, 4'h0, '0, '0, '0, 1'b1, 1'b0); cycle();
    end
    check("mul_ffff_res", out_result, 16'h0001);
    check("mul_ffff_z", flags[1], 1'b0);

    // Flush eight cycles into a multiply
    drive(1'b1, 4'hE, 16'h1234, 16'h0077, 32'hE000_0001, 1'b1, 1'b0); cycle();
    saved_flags = flags;
    repeat (8) begin
      drive(1'b0, 4'h0, '0, '0, '0, 1'b1, 1'b0); cycle();
    end
    drive(1'b1, 4'h0, 16'h5555, 16'h0001, 32'hE000_0002, 1'b1, 1'b1); cycle();
    check("flush_busy", busy, 1'b0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_flags", flags, saved_flags);
    drive(1'b1, 4'h0, 16'h0001, 16'h0002, 32'hE000_0003, 1'b1, 1'b0); cycle();
    check("post_flush_res", out_result, 16'h0003);

    // Asynchronous reset in the middle of a multiply
    drive(1'b1, 4'hE, 16'h00F0, 16'h0011, 32'hF000_0001, 1'b1, 1'b0); cycle();
    repeat (5) begin
      drive(1'b0, 4'h0, '0, '0, '0, 1'b1, 1'b0); cycle();
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_res", out_result, 16'h0000);
    check("async_rst_flags", flags, 3'b000);
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'hE : op_tab[$urandom_range(0, 11)];
      drive($urandom_range(0, 9) < 7, op, rnd_operand(), rnd_operand(), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exec_unit_pipe.md
# exec_unit_pipe

Parametrised execute-stage successor: a single registered EX stage with valid/ready handshakes on both sides, width-generic ALU (saturating add/sub, XOR, shifts/rotate, byte-load ops, pass-through), and an iterative multi-cycle multiplier that back-pressures decode while busy. Sits between decode and memory stages. Carries an opaque control tag (rd, mem/wb/branch controls) alongside the result and maintains the NZV flag register consumed by branch resolution.

## Interface
- WIDTH, 16, datapath width; power of 2, >= 8. SHW = log2(WIDTH) (derived).
- TAG_W, 32, width of opaque passthrough tag.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of in-flight work (branch mispredict).
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  4  operation code.
- in_src1, in_src2  in  WIDTH  operands (already muxed reg/pc/imm).
- in_tag  in  TAG_W  passthrough control bundle.
- out_valid  out  1  result register holds a valid instruction.
- out_ready  in  1  memory stage consumes the result.
- out_result  out  WIDTH  registered result.
- out_tag  out  TAG_W  registered tag of that result.
- flags  out  3  {N,Z,V}, registered.
- busy  out  1  multiplier iterating.

## Operation
- Ops: 0 ADD sat; 1 SUB sat (src1-src2); 2 XOR; 4 SLL; 5 SRA; 6 ROR; 8 PASS src1; 9 LLB {src1[W-1:W/2], src2[W/2-1:0]}; A LHB {src2[W/2-1:0], src1[W/2-1:0]}; B ADD wrap (address calc); E MUL. Others: result 0, no flag update.
- Shift/rotate amount = src2[SHW-1:0]; SRA sign-fills; ROR rotates right.
- Saturation: signed overflow if operand signs (src2 inverted for SUB) agree and sum sign differs; result clamps to 0111..1 (positive overflow) or 1000..0 (negative overflow); V = overflow.
- MUL: unsigned shift-add, one multiplier bit per cycle, WIDTH iterations, result = low WIDTH bits of product (identical for signed). Internal: multiplicand, multiplier, accumulator, SHW+1-bit counter.
- Flags update only on the edge a result is written to the output register: ADD/SUB write N,Z,V; XOR/SLL/SRA/ROR/MUL write Z only (N,V hold); others hold. N = result MSB, Z = (result == 0).
- in_ready = !busy && !flush && (!out_valid || out_ready).
- Accept (in_valid && in_ready), non-MUL: output register loads result/tag, out_valid=1.
- Accept MUL: busy=1, out_valid=0 (prior output consumed same edge), operands/tag captured.
- MUL completion: on the edge the counter reaches WIDTH, output loads product/tag, out_valid=1, busy=0.
- out_valid && !out_ready: result, tag held stable; no accept.
- flush: next edge out_valid=0, busy=0, counter=0; no input accepted; flags unchanged, aborted MUL writes nothing.
- Reset (any time, incl. mid-MUL): out_valid=0, busy=0, out_result=0, out_tag=0, flags=000, counter=0; in_ready=1 once rst deasserts.

## Timing
- Non-MUL latency: accepted at edge k, out_valid/out_result visible after edge k; throughput 1/cycle with out_ready=1.
- MUL: accepted at edge k, out_valid after edge k+WIDTH; in_ready=0 for edges k+1..k+WIDTH; next accept earliest at edge k+WIDTH+1 if out_ready.
- flags visible the cycle after the producing edge, same cycle as out_valid.
- flush and in_valid same cycle: flush wins. flush and MUL completion same edge: flush wins, no output.
- All outputs registered except in_ready (combinational from state, flush, out_ready).

## Test plan
- Reset: assert rst mid-cycle async -> out_valid=0, flags=000, out_result=0 immediately; release -> in_ready=1.
- ADD 0x7FFF+0x0001 (WIDTH=16) -> out_result 0x7FFF, flags N0Z0V1; SUB 0x8000-0x0001 -> 0x8000, N1Z0V1; SUB 0x0005-0x0005 -> 0x0000, N0Z1V0.
- After flags=101, XOR 0x00FF^0x00FF -> 0x0000, flags 111 (N,V held); ROR 0x0001 by 1 -> 0x8000, Z=0; SRA 0x8000 by 15 -> 0xFFFF.
- Back-pressure: two ADDs back-to-back, out_ready=0 for 3 cycles -> in_ready=0, first result/tag held stable, second accepted the edge out_ready rises.
- MUL 0x0003*0x0005 accepted at edge k -> busy 16 cycles, in_ready=0, out_result 0x000F with correct tag after edge k+16; MUL 0xFFFF*0xFFFF -> 0x0001, Z=0.
- flush 8 cycles into MUL -> busy=0, no out_valid, flags unchanged, in_ready=1 next cycle; subsequent ADD 1+2 -> 0x0003.
